// File: rtl/alu_muldiv_seq_pkg.sv
// Op codes, FSM states and decode helpers for the sequential multiply/divide unit.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package MDU_OP;

  // Encoded in funct3 order so instruction decode maps straight onto the enum.
  typedef enum bit [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state;

  // The upper funct3 bit separates the divide family from the multiply family.
  function automatic logic is_div(input mdu_op op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; the owning FSM decides when the step result is registered.
//
// Ports:
//   rem_in / quo_in  partial remainder and quotient register (dividend bits shift out of quo MSB)
//   divisor          unsigned divisor magnitude
//   rem_out/quo_out  values after this iteration; the new quotient bit enters quo LSB
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // The remainder is always below the divisor, so a non-negative difference fits in
  // XLEN bits and the extra top bit acts purely as the borrow flag.
  always_comb begin
    rem_out = shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M multiply/divide unit, radix-2 (one bit per cycle), beside the execute-stage ALU.
// Latency: XLEN+1 cycles accept-to-out_valid; divide-by-zero and signed overflow in 1 cycle.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid && out_ready; flush kills.
//
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_op (MDU_OP::mdu_op), in_a, in_b, in_tag   operation request
//   flush                                                           drop any in-flight op
//   out_valid/out_ready, out_result, out_tag                        result handshake
//   busy                                                            state != IDLE
//
// Build option: define MDU_EARLY_OUT_EN to let multiplies finish as soon as the remaining
// multiplier bits are all zero (latency = MSB position of |b| + 2). Divides are unaffected.
module alu_muldiv_seq
  import MDU_OP::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state          state;
  mdu_op             op_q;
  logic [CW-1:0]     counter;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   divisor;
  logic              neg_q;   // product sign for multiplies, quotient sign for divides
  logic              neg_r;   // remainder sign follows the dividend

  // ---------------- accept-side decode ----------------
  mdu_op           op_in;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  assign op_in    = mdu_op'(in_op);
  assign a_signed = (op_in == MDU_MUL) || (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                    (op_in == MDU_DIV) || (op_in == MDU_REM);
  assign b_signed = (op_in == MDU_MUL) || (op_in == MDU_MULH) ||
                    (op_in == MDU_DIV) || (op_in == MDU_REM);
  assign sa       = a_signed & in_a[XLEN-1];
  assign sb       = b_signed & in_b[XLEN-1];
  assign mag_a    = sa ? (~in_a + 1'b1) : in_a;
  assign mag_b    = sb ? (~in_b + 1'b1) : in_b;

  assign div_zero = (in_b == '0);
  assign div_ovf  = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                    (in_a == MOST_NEG) && (in_b == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = is_rem(op_in) ? in_a : '1;
    else          special_res = is_rem(op_in) ? '0   : in_a;
  end

  // ---------------- multiply step ----------------
  logic [2*XLEN-1:0] prod_nx;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   mplier_nx;
  logic [XLEN-1:0]   mul_res;

  assign prod_nx   = mplier[0] ? (prod + mcand) : prod;
  assign mplier_nx = mplier >> 1;
  assign prod_fin  = neg_q ? (~prod_nx + 1'b1) : prod_nx;
  assign mul_res   = (op_q == MDU_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

  // ---------------- divide step ----------------
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] div_res;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  assign div_res = is_rem(op_q) ? (neg_r ? (~rem_nx + 1'b1) : rem_nx)
                                : (neg_q ? (~quo_nx + 1'b1) : quo_nx);

  // Last CALC cycle: the counter has run out, or (optionally) a multiply has no set
  // multiplier bits left, so further iterations would add nothing.
  logic calc_last;
`ifdef MDU_EARLY_OUT_EN
  assign calc_last = (counter == '0) || (!is_div(op_q) && (mplier_nx == '0));
`else
  assign calc_last = (counter == '0);
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      counter    <= '0;
      op_q       <= MDU_MUL;
      mcand      <= '0;
      prod       <= '0;
      mplier     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor    <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            op_q     <= op_in;
            out_tag  <= in_tag;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (is_div(op_in) && (div_zero || div_ovf)) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= special_res;
            end else begin
              state   <= CALC;
              counter <= CW'(XLEN - 1);
              mcand   <= {{XLEN{1'b0}}, mag_a};
              mplier  <= mag_b;
              prod    <= '0;
              // Dividend magnitude starts in the quotient register and shifts out MSB first.
              rem_q   <= '0;
              quo_q   <= mag_a;
              divisor <= mag_b;
              neg_q   <= sa ^ sb;
              neg_r   <= sa;
            end
          end
        end

        CALC: begin
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            // Both datapaths advance every cycle; only the one matching op_q is used.
            prod    <= prod_nx;
            mcand   <= mcand << 1;
            mplier  <= mplier_nx;
            rem_q   <= rem_nx;
            quo_q   <= quo_nx;
            counter <= counter - 1'b1;
            if (calc_last) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= is_div(op_q) ? div_res : mul_res;
            end
          end
        end

        DONE: begin
          // flush and a consumer take leave the same way; the result is dropped either way.
          if (flush || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq (XLEN=32, TAG_W=5).
// Latency: expected accept-to-out_valid cycles come from the reference model below.
// Backpressure: exercises out_ready stalls, flush in every state and async reset mid-op.
module tb_alu_muldiv_seq;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa_;
    longint     sb_;
    longint     ub;
    logic [63:0] p;
    sa_ = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub  = longint'({32'b0, b});
    p   = '0;
    case (op)
      3'd0: begin p = sa_ * sb_; return p[31:0]; end
      3'd1: begin p = sa_ * sb_; return p[63:32]; end
      3'd2: begin p = sa_ * ub;  return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa_ / sb_; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa_ % sb_; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the accept edge (counted as 1 when out_valid is visible right after it).
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mb;
    int          msb;
    if (op >= 3'd4) begin
      if (b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
    mb  = ((op == 3'd0 || op == 3'd1) && b[31]) ? (0 - b) : b;
    msb = -1;
    for (int i = 0; i < 32; i++) if (mb[i]) msb = i;
`ifdef MDU_EARLY_OUT_EN
    return (msb < 0) ? 2 : msb + 2;
`else
    return (msb < -2) ? 0 : XLEN + 1;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_result !== '0)  begin errors++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    checks++; if (out_tag !== '0)     begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[11];
    int   lat;
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd7,          32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{3'd7, 32'd7,          32'd0,          32'd7};
    vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{3'd0, 32'd5,          32'd3,          32'd15};
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 1));
      wait_out("directed", lat);
      checks++;
      if (out_result !== vecs[i].exp) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, out_result, vecs[i].exp);
      end
      checks++;
      if (out_tag !== TAG_W'(i + 1)) begin
        errors++;
        $display("FAIL directed_tag[%0d]: got %0d want %0d", i, out_tag, i + 1);
      end
      checks++;
      if (lat != exp_lat(vecs[i].op, vecs[i].a, vecs[i].b)) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat,
                 exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    int               lat;
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      tag = TAG_W'($urandom_range(0, 31));
      issue(op, a, b, tag);
      wait_out("random", lat);
      checks++;
      if (out_result !== model(op, a, b)) begin
        errors++;
        $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, out_result, model(op, a, b));
      end
      checks++;
      if (out_tag !== tag) begin
        errors++;
        $display("FAIL random_tag: got %0d want %0d", out_tag, tag);
      end
      checks++;
      if (lat != exp_lat(op, a, b)) begin
        errors++;
        $display("FAIL random_latency op=%0d b=%h: got %0d want %0d", op, b, lat, exp_lat(op, a, b));
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    a   = $urandom | 32'h1;
    b   = $urandom | 32'h8000_0000;
    exp = model(3'd3, a, b);
    issue(3'd3, a, b, 5'd9);
    wait_out("backpressure", lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_result !== exp) begin errors++; $display("FAIL bp_result[%0d]: got %h want %h", i, out_result, exp); end
      checks++; if (out_tag !== 5'd9)   begin errors++; $display("FAIL bp_tag[%0d]: got %0d want 9", i, out_tag); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      @(posedge clk); #1;
    end
    consume();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    // Back-to-back: the very next cycle accepts a new op.
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
    wait_out("b2b", lat);
    checks++; if (out_result !== 32'd14) begin errors++; $display("FAIL b2b_result: got %h want %h", out_result, 32'd14); end
    consume();
  endtask

  task automatic test_flush();
    bit rose;
    int lat;
    // Flush during CALC.
    issue(3'd4, $urandom, 32'd7, 5'd4);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_calc_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL flush_calc_busy: got %b want 0", busy); end
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) rose = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (rose) begin errors++; $display("FAIL flush_calc_out_valid: got 1 want 0 throughout"); end

    // Flush in IDLE blocks acceptance (a divide-by-zero would otherwise show out_valid at once).
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd5; in_a = 32'd7; in_b = 32'd0; in_tag = 5'd6;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_out_valid: got %b want 0", out_valid); end

    // Flush in DONE together with out_ready.
    issue(3'd5, 32'd7, 32'd0, 5'd6);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_done_setup: got %b want 1", out_valid); end
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_done_in_ready: got %b want 1", in_ready); end

    // Unit still computes correctly after flushes.
    issue(3'd0, 32'd1234, 32'd5678, 5'd11);
    wait_out("post_flush", lat);
    checks++; if (out_result !== 32'd7006652) begin errors++; $display("FAIL post_flush_result: got %h want %h", out_result, 32'd7006652); end
    consume();
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    issue(3'd1, $urandom, $urandom | 32'h8000_0000, 5'h1F);
    repeat (5) begin @(posedge clk); #1; end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    checks++; if (out_result !== '0)  begin errors++; $display("FAIL arst_out_result: got %h want 0", out_result); end
    checks++; if (out_tag !== '0)     begin errors++; $display("FAIL arst_out_tag: got %h want 0", out_tag); end
    @(posedge clk); #1;
    rst = 1'b0;
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    issue(3'd7, a, b, 5'd2);
    wait_out("post_reset", lat);
    checks++; if (out_result !== a % b) begin errors++; $display("FAIL post_reset_result: got %h want %h", out_result, a % b); end
    consume();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
